// File: rtl/id_exe_issue_reg_pkg.sv
// Shared definitions for the ID/EXE issue register: forwarding select
// encodings, ALU opcode width and the control-field struct of the slot.
package id_exe_issue_reg_pkg;

    localparam int ALUOP_W = 4;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EXE = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    // Control fields of the ID/EXE slot. Address and datapath fields are
    // held beside it because their widths are module parameters.
    typedef struct packed {
        logic               valid;
        logic               mem_to_reg;
        logic               mem_write;
        logic [ALUOP_W-1:0] alu_op;
    } id_exe_t;

    localparam id_exe_t ID_EXE_BUBBLE = '{valid: 1'b0, mem_to_reg: 1'b0,
                                          mem_write: 1'b0, alu_op: '0};

endpackage

// File: rtl/id_exe_issue_reg_fwd_mux.sv
// DW-wide 4:1 operand forwarding select (RF / EXE / MEM / WB).
module fwd_mux
    import id_exe_issue_reg_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [1:0]    i_sel,
    input  logic [DW-1:0] i_rf,
    input  logic [DW-1:0] i_exe,
    input  logic [DW-1:0] i_mem,
    input  logic [DW-1:0] i_wb,
    output logic [DW-1:0] o_data
);

    // Pure combinational select; no added latency on the operand path.
    always_comb begin
        o_data = i_rf;
        case (i_sel)
            FWD_RF:  o_data = i_rf;
            FWD_EXE: o_data = i_exe;
            FWD_MEM: o_data = i_mem;
            FWD_WB:  o_data = i_wb;
            default: o_data = i_rf;
        endcase
    end

endmodule

// File: rtl/id_exe_issue_reg.sv
// ID/EXE issue register: applies forwarding selects, then loads, holds,
// or bubbles the ID/EXE slot. Update priority: rst, Flush, EXE_Hold,
// ID_EXE_Stall, load. A bubble always has RegWaddr/MemToReg/MemWrite at 0
// so it can neither raise a false hazard nor write memory.
// Optional feature macro: STALL_PERF_CNT_EN adds saturating stall_cnt and
// hold_cnt outputs.
module id_exe_issue_reg
    import id_exe_issue_reg_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_ID,
    input  logic [1:0]         RegRdata1_src,
    input  logic [1:0]         RegRdata2_src,
    input  logic [DW-1:0]      RegRdata1_RF,
    input  logic [DW-1:0]      RegRdata2_RF,
    input  logic [DW-1:0]      ALUResult_EXE,
    input  logic [DW-1:0]      ALUResult_EXE_MEM,
    input  logic [DW-1:0]      RegWdata_WB,
    input  logic               ID_EXE_Stall,
    input  logic               EXE_Hold,
    input  logic               Flush,
    input  logic [AW-1:0]      RegWaddr_ID,
    input  logic               MemToReg_ID,
    input  logic               MemWrite_ID,
    input  logic [ALUOP_W-1:0] ALUop_ID,
    input  logic [DW-1:0]      Imm_ID,
    input  logic [DW-1:0]      PC_ID,
    output logic [DW-1:0]      RegRdata1_ID,
    output logic [DW-1:0]      RegRdata2_ID,
    output logic               valid_ID_EXE,
    output logic [DW-1:0]      RegRdata1_ID_EXE,
    output logic [DW-1:0]      RegRdata2_ID_EXE,
    output logic [AW-1:0]      RegWaddr_ID_EXE,
    output logic               MemToReg_ID_EXE,
    output logic               MemWrite_ID_EXE,
    output logic [ALUOP_W-1:0] ALUop_ID_EXE,
    output logic [DW-1:0]      Imm_ID_EXE,
    output logic [DW-1:0]      PC_ID_EXE,
    output logic               ID_Ready
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        hold_cnt
`endif
);

    logic [DW-1:0] w_fwd1;
    logic [DW-1:0] w_fwd2;
    id_exe_t       w_load_ctrl;
    logic [AW-1:0] w_load_waddr;

    id_exe_t       r_ctrl;
    logic [AW-1:0] r_waddr;
    logic [DW-1:0] r_rd1;
    logic [DW-1:0] r_rd2;
    logic [DW-1:0] r_imm;
    logic [DW-1:0] r_pc;

    fwd_mux #(.DW(DW)) u_fwd1 (
        .i_sel  (RegRdata1_src),
        .i_rf   (RegRdata1_RF),
        .i_exe  (ALUResult_EXE),
        .i_mem  (ALUResult_EXE_MEM),
        .i_wb   (RegWdata_WB),
        .o_data (w_fwd1)
    );

    fwd_mux #(.DW(DW)) u_fwd2 (
        .i_sel  (RegRdata2_src),
        .i_rf   (RegRdata2_RF),
        .i_exe  (ALUResult_EXE),
        .i_mem  (ALUResult_EXE_MEM),
        .i_wb   (RegWdata_WB),
        .o_data (w_fwd2)
    );

    // Slot contents for a normal load; an invalid ID instruction loads with
    // its hazard-visible and side-effecting fields forced to 0.
    always_comb begin
        w_load_ctrl.valid      = valid_ID;
        w_load_ctrl.mem_to_reg = valid_ID & MemToReg_ID;
        w_load_ctrl.mem_write  = valid_ID & MemWrite_ID;
        w_load_ctrl.alu_op     = ALUop_ID;
        w_load_waddr           = valid_ID ? RegWaddr_ID : '0;
    end

    // ID/EXE slot update with rst > Flush > EXE_Hold > ID_EXE_Stall > load.
    always_ff @(posedge clk) begin
        if (rst || Flush || (!EXE_Hold && ID_EXE_Stall)) begin
            r_ctrl  <= ID_EXE_BUBBLE;
            r_waddr <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_pc    <= '0;
        end else if (!EXE_Hold) begin
            r_ctrl  <= w_load_ctrl;
            r_waddr <= w_load_waddr;
            r_rd1   <= w_fwd1;
            r_rd2   <= w_fwd2;
            r_imm   <= Imm_ID;
            r_pc    <= PC_ID;
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_hold_cnt;
    logic        w_stall_bubble;

    // A stall bubble is one the stall itself inserts (not masked by hold or flush).
    assign w_stall_bubble = ID_EXE_Stall && !EXE_Hold && !Flush;

    // Saturating event counters, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_hold_cnt  <= '0;
        end else begin
            if (w_stall_bubble && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (EXE_Hold && (r_hold_cnt != 32'hFFFF_FFFF))
                r_hold_cnt <= r_hold_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign hold_cnt  = r_hold_cnt;
`endif

    assign RegRdata1_ID     = w_fwd1;
    assign RegRdata2_ID     = w_fwd2;
    assign valid_ID_EXE     = r_ctrl.valid;
    assign MemToReg_ID_EXE  = r_ctrl.mem_to_reg;
    assign MemWrite_ID_EXE  = r_ctrl.mem_write;
    assign ALUop_ID_EXE     = r_ctrl.alu_op;
    assign RegWaddr_ID_EXE  = r_waddr;
    assign RegRdata1_ID_EXE = r_rd1;
    assign RegRdata2_ID_EXE = r_rd2;
    assign Imm_ID_EXE       = r_imm;
    assign PC_ID_EXE        = r_pc;
    assign ID_Ready         = ~(ID_EXE_Stall | EXE_Hold);

endmodule

// File: tb/tb_id_exe_issue_reg.sv
// Directed bench for id_exe_issue_reg. Inputs change 1 time unit after a
// rising edge; registered outputs are sampled at that same point.
module tb_id_exe_issue_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_ID;
    logic [1:0]  RegRdata1_src, RegRdata2_src;
    logic [31:0] RegRdata1_RF, RegRdata2_RF, ALUResult_EXE, ALUResult_EXE_MEM, RegWdata_WB;
    logic        ID_EXE_Stall, EXE_Hold, Flush;
    logic [4:0]  RegWaddr_ID;
    logic        MemToReg_ID, MemWrite_ID;
    logic [3:0]  ALUop_ID;
    logic [31:0] Imm_ID, PC_ID;
    logic [31:0] RegRdata1_ID, RegRdata2_ID;
    logic        valid_ID_EXE;
    logic [31:0] RegRdata1_ID_EXE, RegRdata2_ID_EXE;
    logic [4:0]  RegWaddr_ID_EXE;
    logic        MemToReg_ID_EXE, MemWrite_ID_EXE;
    logic [3:0]  ALUop_ID_EXE;
    logic [31:0] Imm_ID_EXE, PC_ID_EXE;
    logic        ID_Ready;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cnt, hold_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_exe_issue_reg dut (
        .clk               (clk),
        .rst               (rst),
        .valid_ID          (valid_ID),
        .RegRdata1_src     (RegRdata1_src),
        .RegRdata2_src     (RegRdata2_src),
        .RegRdata1_RF      (RegRdata1_RF),
        .RegRdata2_RF      (RegRdata2_RF),
        .ALUResult_EXE     (ALUResult_EXE),
        .ALUResult_EXE_MEM (ALUResult_EXE_MEM),
        .RegWdata_WB       (RegWdata_WB),
        .ID_EXE_Stall      (ID_EXE_Stall),
        .EXE_Hold          (EXE_Hold),
        .Flush             (Flush),
        .RegWaddr_ID       (RegWaddr_ID),
        .MemToReg_ID       (MemToReg_ID),
        .MemWrite_ID       (MemWrite_ID),
        .ALUop_ID          (ALUop_ID),
        .Imm_ID            (Imm_ID),
        .PC_ID             (PC_ID),
        .RegRdata1_ID      (RegRdata1_ID),
        .RegRdata2_ID      (RegRdata2_ID),
        .valid_ID_EXE      (valid_ID_EXE),
        .RegRdata1_ID_EXE  (RegRdata1_ID_EXE),
        .RegRdata2_ID_EXE  (RegRdata2_ID_EXE),
        .RegWaddr_ID_EXE   (RegWaddr_ID_EXE),
        .MemToReg_ID_EXE   (MemToReg_ID_EXE),
        .MemWrite_ID_EXE   (MemWrite_ID_EXE),
        .ALUop_ID_EXE      (ALUop_ID_EXE),
        .Imm_ID_EXE        (Imm_ID_EXE),
        .PC_ID_EXE         (PC_ID_EXE),
        .ID_Ready          (ID_Ready)
`ifdef STALL_PERF_CNT_EN
        ,
        .stall_cnt         (stall_cnt),
        .hold_cnt          (hold_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        rst = 0; valid_ID = 0; RegRdata1_src = 2'b00; RegRdata2_src = 2'b00;
        RegRdata1_RF = 32'h0; RegRdata2_RF = 32'h0; ALUResult_EXE = 32'h0;
        ALUResult_EXE_MEM = 32'h0; RegWdata_WB = 32'h0;
        ID_EXE_Stall = 0; EXE_Hold = 0; Flush = 0;
        RegWaddr_ID = 5'd0; MemToReg_ID = 0; MemWrite_ID = 0; ALUop_ID = 4'd0;
        Imm_ID = 32'h0; PC_ID = 32'h0;
    endtask

    // Present a valid instruction with recognisable fields.
    task automatic drive_instr(input logic [4:0] waddr, input logic [31:0] imm, input logic [31:0] pc);
        valid_ID = 1; RegWaddr_ID = waddr; MemToReg_ID = 1; MemWrite_ID = 1;
        ALUop_ID = 4'h5; Imm_ID = imm; PC_ID = pc;
    endtask

    task automatic test_reset();
        drive_idle();
        drive_instr(5'd17, 32'hDEAD, 32'h40);
        rst = 1;
        step();
        n_vec++;
        if ({valid_ID_EXE, RegWaddr_ID_EXE, MemToReg_ID_EXE, MemWrite_ID_EXE, ALUop_ID_EXE} !== 12'h0) begin
            n_err++; $display("FAIL reset_ctrl: got %h want 0", {valid_ID_EXE, RegWaddr_ID_EXE, MemToReg_ID_EXE, MemWrite_ID_EXE, ALUop_ID_EXE});
        end
        n_vec++;
        if ({RegRdata1_ID_EXE, RegRdata2_ID_EXE, Imm_ID_EXE, PC_ID_EXE} !== 128'h0) begin
            n_err++; $display("FAIL reset_data: imm got %h pc got %h want 0", Imm_ID_EXE, PC_ID_EXE);
        end
        n_vec++;
        if (ID_Ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready: got %b want 1", ID_Ready);
        end
        rst = 0;
    endtask

    task automatic test_forward();
        logic [31:0] exp2 [4];
        drive_idle();
        RegRdata1_RF = 32'h1111_0000; RegRdata2_RF = 32'h2222_0000;
        ALUResult_EXE = 32'h1234; ALUResult_EXE_MEM = 32'h5678; RegWdata_WB = 32'h9ABC;
        exp2[0] = 32'h2222_0000; exp2[1] = 32'h1234; exp2[2] = 32'h5678; exp2[3] = 32'h9ABC;
        RegRdata1_src = 2'b01;
        for (int s = 0; s < 4; s++) begin
            RegRdata2_src = s[1:0];
            #1;
            n_vec++;
            if (RegRdata2_ID !== exp2[s]) begin
                n_err++; $display("FAIL fwd_rt_sel%0d: got %h want %h", s, RegRdata2_ID, exp2[s]);
            end
        end
        n_vec++;
        if (RegRdata1_ID !== 32'h1234) begin
            n_err++; $display("FAIL fwd_rs_comb: got %h want 00001234", RegRdata1_ID);
        end
        RegRdata2_src = 2'b10;
        drive_instr(5'd9, 32'h0000_0ABC, 32'h100);
        step();
        n_vec++;
        if (RegRdata1_ID_EXE !== 32'h1234 || RegRdata2_ID_EXE !== 32'h5678) begin
            n_err++; $display("FAIL fwd_reg: got %h/%h want 00001234/00005678", RegRdata1_ID_EXE, RegRdata2_ID_EXE);
        end
        n_vec++;
        if ({valid_ID_EXE, RegWaddr_ID_EXE, MemToReg_ID_EXE, MemWrite_ID_EXE, ALUop_ID_EXE, Imm_ID_EXE, PC_ID_EXE}
            !== {1'b1, 5'd9, 1'b1, 1'b1, 4'h5, 32'h0ABC, 32'h100}) begin
            n_err++; $display("FAIL load_fields: waddr %0d imm %h pc %h want 9/00000abc/00000100", RegWaddr_ID_EXE, Imm_ID_EXE, PC_ID_EXE);
        end
    endtask

    task automatic test_invalid_load();
        drive_idle();
        drive_instr(5'd7, 32'h77, 32'h200);
        valid_ID = 0;
        step();
        n_vec++;
        if ({valid_ID_EXE, RegWaddr_ID_EXE, MemToReg_ID_EXE, MemWrite_ID_EXE} !== 8'h0 || Imm_ID_EXE !== 32'h77) begin
            n_err++; $display("FAIL invalid_load: v %b waddr %0d mw %b imm %h want 0/0/0/00000077", valid_ID_EXE, RegWaddr_ID_EXE, MemWrite_ID_EXE, Imm_ID_EXE);
        end
    endtask

    task automatic test_stall();
        drive_idle();
        drive_instr(5'd9, 32'h33, 32'h300);
        ID_EXE_Stall = 1;
        #1;
        n_vec++;
        if (ID_Ready !== 1'b0) begin
            n_err++; $display("FAIL stall_ready: got %b want 0", ID_Ready);
        end
        step();
        n_vec++;
        if (valid_ID_EXE !== 1'b0 || MemWrite_ID_EXE !== 1'b0 || RegWaddr_ID_EXE !== 5'd0 || MemToReg_ID_EXE !== 1'b0) begin
            n_err++; $display("FAIL stall_bubble: v %b mw %b waddr %0d want 0/0/0", valid_ID_EXE, MemWrite_ID_EXE, RegWaddr_ID_EXE);
        end
        ID_EXE_Stall = 0;
        RegRdata1_src = 2'b11; RegWdata_WB = 32'hF00D;
        step();
        n_vec++;
        if (valid_ID_EXE !== 1'b1 || MemWrite_ID_EXE !== 1'b1 || RegWaddr_ID_EXE !== 5'd9 || RegRdata1_ID_EXE !== 32'hF00D) begin
            n_err++; $display("FAIL stall_reload: v %b mw %b waddr %0d rs %h want 1/1/9/0000f00d", valid_ID_EXE, MemWrite_ID_EXE, RegWaddr_ID_EXE, RegRdata1_ID_EXE);
        end
    endtask

    task automatic test_hold();
        drive_idle();
        drive_instr(5'd3, 32'hAAAA, 32'h400);
        RegRdata1_RF = 32'h11;
        step();
        for (int i = 0; i < 3; i++) begin
            EXE_Hold = 1; ID_EXE_Stall = 1;
            drive_instr(5'(i + 10), 32'(i), 32'h500 + 32'(i));
            RegRdata1_RF = 32'h99 + 32'(i);
            #1;
            n_vec++;
            if (ID_Ready !== 1'b0) begin
                n_err++; $display("FAIL hold_ready%0d: got %b want 0", i, ID_Ready);
            end
            step();
            n_vec++;
            if (valid_ID_EXE !== 1'b1 || RegWaddr_ID_EXE !== 5'd3 || Imm_ID_EXE !== 32'hAAAA || PC_ID_EXE !== 32'h400 || RegRdata1_ID_EXE !== 32'h11) begin
                n_err++; $display("FAIL hold_keep%0d: v %b waddr %0d imm %h pc %h rs %h want 1/3/0000aaaa/00000400/00000011",
                                  i, valid_ID_EXE, RegWaddr_ID_EXE, Imm_ID_EXE, PC_ID_EXE, RegRdata1_ID_EXE);
            end
        end
    endtask

    task automatic test_flush_hold();
        // Slot is still valid from the hold test.
        EXE_Hold = 1; ID_EXE_Stall = 0; Flush = 1;
        step();
        n_vec++;
        if (valid_ID_EXE !== 1'b0 || RegWaddr_ID_EXE !== 5'd0 || MemWrite_ID_EXE !== 1'b0) begin
            n_err++; $display("FAIL flush_hold: v %b waddr %0d mw %b want 0/0/0", valid_ID_EXE, RegWaddr_ID_EXE, MemWrite_ID_EXE);
        end
        drive_idle();
        drive_instr(5'd21, 32'h21, 32'h600);
        Flush = 1; ID_EXE_Stall = 1;
        step();
        n_vec++;
        if (valid_ID_EXE !== 1'b0 || RegWaddr_ID_EXE !== 5'd0) begin
            n_err++; $display("FAIL flush_stall: v %b waddr %0d want 0/0", valid_ID_EXE, RegWaddr_ID_EXE);
        end
        Flush = 0; ID_EXE_Stall = 0;
        step();
        n_vec++;
        if (valid_ID_EXE !== 1'b1 || RegWaddr_ID_EXE !== 5'd21) begin
            n_err++; $display("FAIL flush_reload: v %b waddr %0d want 1/21", valid_ID_EXE, RegWaddr_ID_EXE);
        end
    endtask

    task automatic test_reset_hold();
        drive_idle();
        drive_instr(5'd12, 32'hC0DE, 32'h700);
        step();
        EXE_Hold = 1;
        step();
        rst = 1;
        step();
        n_vec++;
        if ({valid_ID_EXE, RegWaddr_ID_EXE, MemToReg_ID_EXE, MemWrite_ID_EXE, ALUop_ID_EXE} !== 12'h0 ||
            {RegRdata1_ID_EXE, RegRdata2_ID_EXE, Imm_ID_EXE, PC_ID_EXE} !== 128'h0) begin
            n_err++; $display("FAIL reset_hold: v %b waddr %0d imm %h pc %h want all 0", valid_ID_EXE, RegWaddr_ID_EXE, Imm_ID_EXE, PC_ID_EXE);
        end
`ifdef STALL_PERF_CNT_EN
        n_vec++;
        if (stall_cnt !== 32'd0 || hold_cnt !== 32'd0) begin
            n_err++; $display("FAIL reset_cnt: stall %0d hold %0d want 0/0", stall_cnt, hold_cnt);
        end
`endif
        rst = 0; EXE_Hold = 0;
        step();
        n_vec++;
        if (valid_ID_EXE !== 1'b1 || RegWaddr_ID_EXE !== 5'd12 || Imm_ID_EXE !== 32'hC0DE) begin
            n_err++; $display("FAIL reset_no_residual: v %b waddr %0d imm %h want 1/12/0000c0de", valid_ID_EXE, RegWaddr_ID_EXE, Imm_ID_EXE);
        end
    endtask

`ifdef STALL_PERF_CNT_EN
    task automatic test_counters();
        drive_idle();
        rst = 1;
        step();
        rst = 0;
        ID_EXE_Stall = 1;
        repeat (5) step();
        ID_EXE_Stall = 0;
        EXE_Hold = 1;
        repeat (2) step();
        EXE_Hold = 0;
        n_vec++;
        if (stall_cnt !== 32'd5 || hold_cnt !== 32'd2) begin
            n_err++; $display("FAIL cnt_count: stall %0d hold %0d want 5/2", stall_cnt, hold_cnt);
        end
        force dut.r_stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_stall_cnt;
        ID_EXE_Stall = 1;
        step();
        ID_EXE_Stall = 0;
        n_vec++;
        if (stall_cnt !== 32'hFFFF_FFFF) begin
            n_err++; $display("FAIL cnt_saturate: got %h want ffffffff", stall_cnt);
        end
    endtask
`endif

    initial begin
        drive_idle();
        test_reset();
        test_forward();
        test_invalid_load();
        test_stall();
        test_hold();
        test_flush_hold();
        test_reset_hold();
`ifdef STALL_PERF_CNT_EN
        test_counters();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
